uart_rx_byte_pusher: RTL and testbench

Serial-to-byte receiver sitting directly upstream of the 8-bit-in / 256-bit-out prefetch FIFO in the UART loading path. It recovers 8N1 UART frames from the host RX line, pushes each good byte into the FIFO write port with a one-cycle `wr_en`, and tracks 32-byte word boundaries so downstream control knows when a full 256-bit FIFO word has been assembled. Framing errors and FIFO overflow are reported as sticky flags.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_bit_timer.sv | 46 ++++
 rtl/uart_rx_byte_pusher.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_byte_pusher.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART loading path: receiver FSM
//               state encoding, default clock/baud constants and the
//               clocks-per-bit helper used to size the bit timer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int DEFAULT_CLK_FREQ = 50_000_000;
   localparam int DEFAULT_BAUD     = 115_200;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_PUSH      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } rx_state_e;

   // Integer divide; the result must be at least 4 so the half-bit
   // preload (CLKS_PER_BIT/2 - 1) stays positive.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Loadable down-counter for UART bit timing. Counts down to
//               zero and holds there; o_expire is high while the count is 0.
//               Shared between the RX and TX sides.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_load          - load i_load_val this cycle (wins over count)
//               i_load_val      - value to load
//               o_expire        - count has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_expire
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_load_val;
      end else if (count_q != '0) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_expire = (count_q == '0);

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_rx_byte_pusher.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte_pusher
// Description : 8N1 UART receiver feeding the 8-in/256-out prefetch FIFO.
//               Each good byte is pushed with a one-cycle wr_en, bytes are
//               counted modulo BYTES_PER_WORD and word_done marks the last
//               byte of a FIFO word. Framing errors and dropped bytes are
//               reported through sticky flags cleared by clr_err.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               uart_rx         - asynchronous serial input, idle high
//               wr_vld          - FIFO can accept a byte this cycle
//               wr_en, wr_data  - push strobe and byte to the FIFO
//               word_done       - pulse with the last byte of a word
//               byte_cnt        - bytes pushed in the current word
//               frame_err       - sticky, stop bit sampled low
//               overflow        - sticky, good byte dropped (wr_vld low)
//               clr_err         - clears both sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte_pusher
   import uart_pkg::*;
#(
   parameter  int CLK_FREQ       = DEFAULT_CLK_FREQ,
   parameter  int BAUD           = DEFAULT_BAUD,
   parameter  int BYTES_PER_WORD = 32,
   localparam int CNT_W          = $clog2(BYTES_PER_WORD)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             uart_rx,
   input  logic             wr_vld,
   output logic             wr_en,
   output logic [7:0]       wr_data,
   output logic             word_done,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             frame_err,
   output logic             overflow,
   input  logic             clr_err
);

   localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int               TMR_W        = $clog2(CLKS_PER_BIT);
   // Half-bit preload puts every later sample in the middle of its bit.
   localparam logic [TMR_W-1:0] HALF_LOAD    = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] FULL_LOAD    = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(BYTES_PER_WORD - 1);

   // ------------------------------------------------------------------
   // Two-flop synchroniser, reset to the idle line level
   // ------------------------------------------------------------------
   logic sync1_q, sync1_d;
   logic rx_s_q,  rx_s_d;

   always_comb begin
      sync1_d = uart_rx;
      rx_s_d  = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         rx_s_q  <= rx_s_d;
      end
   end

   // ------------------------------------------------------------------
   // Bit timer
   // ------------------------------------------------------------------
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_expire;

   uart_bit_timer #(
      .WIDTH      (TMR_W)
   ) u_bit_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (tmr_load),
      .i_load_val (tmr_val),
      .o_expire   (tmr_expire)
   );

   // ------------------------------------------------------------------
   // Receive FSM and shift register
   // ------------------------------------------------------------------
   rx_state_e  state_q,   state_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shreg_q,   shreg_d;
   logic       push;
   logic       frame_set;
   logic       ovf_set;

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      push      = 1'b0;
      frame_set = 1'b0;
      ovf_set   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               state_d  = ST_START;
               tmr_load = 1'b1;
               tmr_val  = HALF_LOAD;
            end
         end
         ST_START: begin
            if (tmr_expire) begin
               if (!rx_s_q) begin
                  state_d   = ST_DATA;
                  tmr_load  = 1'b1;
                  tmr_val   = FULL_LOAD;
                  bit_idx_d = 3'd0;
               end else begin
                  // Line back high at mid start bit: a glitch, not a frame.
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (tmr_expire) begin
               // LSB arrives first, so shifting in at the top leaves the
               // byte correctly ordered after eight bits.
               shreg_d  = {rx_s_q, shreg_q[7:1]};
               tmr_load = 1'b1;
               tmr_val  = FULL_LOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (tmr_expire) begin
               if (rx_s_q) begin
                  state_d = ST_PUSH;
               end else begin
                  frame_set = 1'b1;
                  state_d   = ST_WAIT_HIGH;
               end
            end
         end
         ST_PUSH: begin
            // Single-cycle offer; the FIFO either takes it or it is lost.
            state_d = ST_IDLE;
            if (wr_vld) begin
               push = 1'b1;
            end else begin
               ovf_set = 1'b1;
            end
         end
         ST_WAIT_HIGH: begin
            // A held-low line (break) must not look like a new start bit.
            if (rx_s_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_idx_q <= 3'd0;
         shreg_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
      end
   end

   // ------------------------------------------------------------------
   // Word counter and sticky error flags
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] byte_cnt_q,  byte_cnt_d;
   logic             frame_err_q, frame_err_d;
   logic             overflow_q,  overflow_d;

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      if (push) begin
         byte_cnt_d = (byte_cnt_q == CNT_LAST) ? '0 : byte_cnt_q + CNT_W'(1);
      end

      // A set event in the same cycle as clr_err keeps the flag set.
      frame_err_d = frame_err_q;
      if (frame_set) begin
         frame_err_d = 1'b1;
      end else if (clr_err) begin
         frame_err_d = 1'b0;
      end

      overflow_d = overflow_q;
      if (ovf_set) begin
         overflow_d = 1'b1;
      end else if (clr_err) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q  <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         byte_cnt_q  <= byte_cnt_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   // Gated with rst so a reset landing on the PUSH cycle emits nothing.
   assign wr_en     = push & ~rst;
   assign wr_data   = shreg_q;
   assign word_done = wr_en & (byte_cnt_q == CNT_LAST);
   assign byte_cnt  = byte_cnt_q;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule : uart_rx_byte_pusher
`default_nettype wire

// File: tb/tb_uart_rx_byte_pusher.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte_pusher
// Description : Self-checking bench for uart_rx_byte_pusher at
//               CLKS_PER_BIT = 16. Directed vector table, hand-written
//               corner sequences and random frames against a frame-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte_pusher;

   localparam int BIT_CYC   = 16;
   localparam int FRAME_CYC = 10 * BIT_CYC;
   localparam int BPW       = 32;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       uart_rx = 1'b1;
   logic       wr_vld  = 1'b0;
   logic       clr_err = 1'b0;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       word_done;
   logic [4:0] byte_cnt;
   logic       frame_err;
   logic       overflow;

   always #5 clk = ~clk;

   uart_rx_byte_pusher #(
      .CLK_FREQ       (16_000),
      .BAUD           (1_000),
      .BYTES_PER_WORD (BPW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .wr_vld    (wr_vld),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .word_done (word_done),
      .byte_cnt  (byte_cnt),
      .frame_err (frame_err),
      .overflow  (overflow),
      .clr_err   (clr_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: bytes in current word and sticky flags.
   int m_cnt  = 0;
   int m_ferr = 0;
   int m_ovf  = 0;

   // Pushes observed by the monitor: {word_done, wr_data}.
   logic [8:0] mon_q[$];
   logic       prev_wr_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h) at %0t",
                    name, act, act, exp, exp, $time);
   endtask

   always @(negedge clk) begin
      if (wr_en) mon_q.push_back({word_done, wr_data});
      if (wr_en && prev_wr_en) begin
         n_checks++;
         $display("FAIL wr_en_width: wr_en high 2 cycles running at %0t", $time);
      end
      prev_wr_en = wr_en;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: bench did not complete by %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input bit bad, input int idx);
      if (idx == 0) return 1'b0;
      else if (idx <= 8) return d[idx-1];
      else return !bad;
   endfunction

   // Drive the first ncyc cycles of a frame; clr_err pulses at cycle clr_cyc.
   task automatic send_frame(input logic [7:0] d, input bit bad, input int clr_cyc, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         uart_rx = frame_bit(d, bad, c / BIT_CYC);
         clr_err = (c == clr_cyc);
         step(1);
      end
      uart_rx = 1'b1;
      clr_err = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      uart_rx = 1'b1;
      step(3);
      rst = 1'b0;
      m_cnt = 0; m_ferr = 0; m_ovf = 0;
      step(2);
   endtask

   // One full frame plus gap, checked against the frame-level model.
   task automatic run_frame(input logic [7:0] d, input bit bad, input bit vld,
                            input int clr_cyc, input int gap);
      int         exp_push;
      int         exp_wd;
      logic [8:0] e;
      exp_push = 0;
      exp_wd   = 0;
      if (clr_cyc >= 0) begin m_ferr = 0; m_ovf = 0; end
      if (bad) m_ferr = 1;
      else if (!vld) m_ovf = 1;
      else begin
         exp_push = 1;
         exp_wd   = (m_cnt == BPW - 1) ? 1 : 0;
         m_cnt    = (m_cnt + 1) % BPW;
      end
      mon_q.delete();
      wr_vld = vld;
      send_frame(d, bad, clr_cyc, FRAME_CYC);
      step(gap);
      check("push_count", mon_q.size(), exp_push);
      if (exp_push == 1 && mon_q.size() > 0) begin
         e = mon_q[0];
         check("wr_data", int'(e[7:0]), int'(d));
         check("word_done", int'(e[8]), exp_wd);
      end
      check("byte_cnt", int'(byte_cnt), m_cnt);
      check("frame_err", int'(frame_err), m_ferr);
      check("overflow", int'(overflow), m_ovf);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         bad;
      bit         vld;
      int         clr_cyc;
      int         gap;
      int         exp_push;
      int         exp_cnt;
      int         exp_ferr;
      int         exp_ovf;
   } vec_t;

   vec_t tbl[4];

   initial begin
      // Hand-derived expectations starting from reset. clr_err at cycle
      // 154 coincides with the stop-bit sample, 155 with the PUSH cycle.
      tbl[0] = '{8'h5A, 1'b0, 1'b1, -1,  4, 1, 1, 0, 0};
      tbl[1] = '{8'hC3, 1'b1, 1'b1, 154, 4, 0, 1, 1, 0};
      tbl[2] = '{8'h11, 1'b0, 1'b1, -1,  4, 1, 2, 1, 0};
      tbl[3] = '{8'hA5, 1'b0, 1'b0, 155, 4, 0, 2, 0, 1};

      reset_dut();
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_wr_data", int'(wr_data), 0);
      check("rst_word_done", int'(word_done), 0);
      check("rst_byte_cnt", int'(byte_cnt), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_overflow", int'(overflow), 0);

      // Directed table: good byte, framing error, recovery, overflow.
      for (int i = 0; i < 4; i++) begin
         run_frame(tbl[i].data, tbl[i].bad, tbl[i].vld, tbl[i].clr_cyc, tbl[i].gap);
         check("tbl_byte_cnt", int'(byte_cnt), tbl[i].exp_cnt);
         check("tbl_frame_err", int'(frame_err), tbl[i].exp_ferr);
         check("tbl_overflow", int'(overflow), tbl[i].exp_ovf);
         check("tbl_push", mon_q.size(), tbl[i].exp_push);
      end

      // clr_err on its own clears the overflow flag.
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      m_ferr = 0; m_ovf = 0;
      check("clr_overflow", int'(overflow), 0);
      check("clr_frame_err", int'(frame_err), 0);

      // Short low glitch: no reception, no flags, then a normal frame.
      mon_q.delete();
      uart_rx = 1'b0;
      step(5);
      uart_rx = 1'b1;
      step(30);
      check("glitch_push", mon_q.size(), 0);
      check("glitch_frame_err", int'(frame_err), 0);
      check("glitch_overflow", int'(overflow), 0);
      run_frame(8'h77, 1'b0, 1'b1, -1, 3);

      // Reset in the middle of data bit 4 of 0xFF, then a clean 0x3C.
      mon_q.delete();
      wr_vld = 1'b1;
      send_frame(8'hFF, 1'b0, -1, 5 * BIT_CYC + BIT_CYC / 2);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      m_cnt = 0; m_ferr = 0; m_ovf = 0;
      step(30);
      check("midrst_push", mon_q.size(), 0);
      check("midrst_byte_cnt", int'(byte_cnt), 0);
      run_frame(8'h3C, 1'b0, 1'b1, -1, 4);

      // 32 back-to-back frames forming one full FIFO word.
      reset_dut();
      for (int i = 0; i < BPW; i++) begin
         run_frame(8'(i), 1'b0, 1'b1, -1, 0);
      end
      check("word_wrap_cnt", int'(byte_cnt), 0);

      // Random frames against the model.
      for (int i = 0; i < 60; i++) begin
         logic [7:0] d;
         bit         bad;
         bit         vld;
         int         clr_cyc;
         int         gap;
         d       = 8'($urandom);
         bad     = ($urandom_range(7) == 0);
         vld     = ($urandom_range(5) != 0);
         clr_cyc = -1;
         if ($urandom_range(3) == 0)
            clr_cyc = ($urandom_range(1) == 1) ? 20 : (bad ? 154 : 155);
         gap     = bad ? 2 + int'($urandom_range(3)) : int'($urandom_range(3));
         run_frame(d, bad, vld, clr_cyc, gap);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_uart_rx_byte_pusher
`default_nettype wire
